sc_regshifter_multicycle: RTL
=============================

Name: sc_regshifter_multicycle

Overview:
Parametrised successor to the single-step load/shift register. It holds a DATAWIDTH_BUS-bit word, and supports a parallel load plus a multi-cycle shift. The shift runs by a programmed amount, one bit position per clock, in one of five modes: logical left, logical right, arithmetic right, rotate left and rotate right. A Busy/Done handshake lets a controlling FSM or datapath sequencer start an operation and wait for it to complete.

Parameters:
DATAWIDTH_BUS, 8, data word width (>=2)
DATAWIDTH_REGSHIFTER_SELECTION, 3, width of the shift mode code
DATAWIDTH_REGSHIFTER_AMOUNT, 3, width of the shift-amount field; equals clog2(DATAWIDTH_BUS)

Ports:
SC_RegSHIFTER_CLOCK_50  in  1  single clock; all state changes on its rising edge
SC_RegSHIFTER_Reset_InHigh  in  1  reset; synchronous, active-high
SC_RegSHIFTER_Load_InLow  in  1  parallel load request, active-low
SC_RegSHIFTER_Start_InLow  in  1  start shift request, active-low
SC_RegSHIFTER_ShiftSelection_InLow  in  DATAWIDTH_REGSHIFTER_SELECTION  mode code
SC_RegSHIFTER_ShiftAmount_In  in  DATAWIDTH_REGSHIFTER_AMOUNT  number of bit positions to shift
SC_RegSHIFTER_DataBUS_In  in  DATAWIDTH_BUS  parallel load data
SC_RegSHIFTER_DataBUS_Out  out  DATAWIDTH_BUS  register contents, driven directly from the flops
SC_RegSHIFTER_Busy_Out  out  1  high while in SHIFT
SC_RegSHIFTER_Done_Out  out  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous, high at a rising edge) forces the following next cycle:
  - register = 0, state = IDLE
  - Busy = 0, Done = 0
  - latched mode, latched amount and counter = 0
- Reset has priority over everything, including reset arriving mid-SHIFT or in DONE. The shift is abandoned with no Done pulse.
- Mode codes:
  - 000 = NOP (hold)
  - 001 = SLL, shift in 0
  - 010 = SRL, shift in 0
  - 011 = SRA, replicate MSB
  - 100 = ROL
  - 101 = ROR
  - 110 and 111 = reserved, treated as NOP
- IDLE state:
  - Load_InLow = 0: register <= DataBUS_In, state stays IDLE. Load has priority over Start when both are asserted.
  - Load_InLow = 1 and Start_InLow = 0: latch mode and amount. If amount = 0, go to DONE. Otherwise set counter = amount and go to SHIFT.
  - Neither asserted: hold.
- SHIFT state:
  - Busy = 1.
  - Each cycle applies one single-bit step of the latched mode to the register and decrements the counter.
  - When the counter equals 1 at the edge, that edge performs the final step and moves to DONE.
  - Load and Start are ignored; input mode and amount changes have no effect.
- DONE state: Done = 1 for exactly one cycle, Busy = 0, register holds. The next edge returns to IDLE unconditionally; Load and Start are ignored in this state.
- Latency: Start sampled at edge k with amount N >= 1.
  - SHIFT steps occur at edges k+1 .. k+N.
  - Done is high between edges k+N and k+N+1.
  - A new Start is accepted at edge k+N+1 or later.
  - Amount 0: Done is high between edges k and k+1.
- NOP or reserved modes still run the full N-cycle sequence with the register unchanged.
- Maximum amount is 2^DATAWIDTH_REGSHIFTER_AMOUNT - 1. Rotate by the full width is not expressible; there is no wrap of the amount.

Optional Feature:
SC_REGSHIFTER_CARRY_EN
- Defined: adds output port SC_RegSHIFTER_Carry_Out (1 bit, reset 0). On each SHIFT step it holds the bit that left the word:
  - SLL and ROL: old MSB
  - SRL, SRA and ROR: old LSB
  - NOP steps: unchanged
  - Parallel load: cleared to 0
- Undefined: the port and its flop are absent; all other behaviour is identical.

Decomposition:
- Package sc_regshifter_pkg holds:
  - mode code localparams (MODE_NOP, MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR)
  - FSM state encoding (ST_IDLE, ST_SHIFT, ST_DONE)
- One combinational sub-module, sc_regshifter_step, takes word, mode and width parameter. It returns the one-bit-stepped word and the shifted-out bit.
- The top module keeps the FSM, counter and registers.

Test Plan:
- Reset, then Load_InLow = 0 with DataIn = 8'hA5 -> Out = 8'hA5 after one edge; Busy = 0, Done = 0.
- From 8'hA5, Start with SLL, amount 3:
  - Out steps 8'h4A, 8'h94, 8'h28 with Busy high for 3 cycles, then a 1-cycle Done.
  - With the macro defined, Carry sequence is 1, 0, 1.
- Load 8'h84, then SRA amount 2 -> 8'hC2, then 8'hE1. Load pulses during SHIFT are ignored and the final value is 8'hE1.
- Load 8'h01, then ROR amount 7 -> final 8'h02. Done rises 7 edges after the Start edge.
- Start with amount 0 -> Done the next cycle, Busy never high, Out unchanged. Load and Start asserted together in IDLE -> the load wins and no shift starts.
- Reset asserted during the 2nd SHIFT cycle of SLL amount 5 on 8'hFF -> next edge Out = 8'h00, Busy = 0, Done never pulses, and a subsequent Start is accepted normally.

Source files
------------

// File: rtl/sc_regshifter_pkg.sv
// Shared definitions for the multi-cycle load/shift register:
// shift mode codes and FSM state encoding.
package sc_regshifter_pkg;

  // Shift mode codes; 3'b110 and 3'b111 are reserved and behave as NOP.
  localparam logic [2:0] MODE_NOP = 3'd0;
  localparam logic [2:0] MODE_SLL = 3'd1;
  localparam logic [2:0] MODE_SRL = 3'd2;
  localparam logic [2:0] MODE_SRA = 3'd3;
  localparam logic [2:0] MODE_ROL = 3'd4;
  localparam logic [2:0] MODE_ROR = 3'd5;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sc_regshifter_step.sv
// Combinational single-bit step of the shifter: given the current word and
// a mode code, returns the word moved by one position, the bit that left
// the word, and whether the mode actually moves bits (NOP/reserved do not).
module sc_regshifter_step
  import sc_regshifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic [WIDTH-1:0] word,
  input  logic [SEL_W-1:0] mode,
  output logic [WIDTH-1:0] word_next,
  output logic             shifted_bit,
  output logic             moves
);

  // One-position step selected by the mode code.
  always_comb begin
    word_next   = word;
    shifted_bit = 1'b0;
    moves       = 1'b0;
    case (mode)
      MODE_SLL: begin
        word_next   = {word[WIDTH-2:0], 1'b0};
        shifted_bit = word[WIDTH-1];
        moves       = 1'b1;
      end
      MODE_SRL: begin
        word_next   = {1'b0, word[WIDTH-1:1]};
        shifted_bit = word[0];
        moves       = 1'b1;
      end
      MODE_SRA: begin
        word_next   = {word[WIDTH-1], word[WIDTH-1:1]};
        shifted_bit = word[0];
        moves       = 1'b1;
      end
      MODE_ROL: begin
        word_next   = {word[WIDTH-2:0], word[WIDTH-1]};
        shifted_bit = word[WIDTH-1];
        moves       = 1'b1;
      end
      MODE_ROR: begin
        word_next   = {word[0], word[WIDTH-1:1]};
        shifted_bit = word[0];
        moves       = 1'b1;
      end
      default: begin
        word_next   = word;
        shifted_bit = 1'b0;
        moves       = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sc_regshifter_multicycle.sv
// Multi-cycle load/shift register with Busy/Done handshake.
// Optional carry output enabled by defining SC_REGSHIFTER_CARRY_EN.
// A Start in IDLE latches mode and amount; the word then moves one bit per
// clock for "amount" clocks, followed by a single-cycle Done.
module sc_regshifter_multicycle
  import sc_regshifter_pkg::*;
#(
  parameter int DATAWIDTH_BUS                  = 8,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 3,
  parameter int DATAWIDTH_REGSHIFTER_AMOUNT    = 3
) (
  input  logic                                      SC_RegSHIFTER_CLOCK_50,
  input  logic                                      SC_RegSHIFTER_Reset_InHigh,
  input  logic                                      SC_RegSHIFTER_Load_InLow,
  input  logic                                      SC_RegSHIFTER_Start_InLow,
  input  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_RegSHIFTER_ShiftSelection_InLow,
  input  logic [DATAWIDTH_REGSHIFTER_AMOUNT-1:0]    SC_RegSHIFTER_ShiftAmount_In,
  input  logic [DATAWIDTH_BUS-1:0]                  SC_RegSHIFTER_DataBUS_In,
  output logic [DATAWIDTH_BUS-1:0]                  SC_RegSHIFTER_DataBUS_Out,
  output logic                                      SC_RegSHIFTER_Busy_Out,
  output logic                                      SC_RegSHIFTER_Done_Out
`ifdef SC_REGSHIFTER_CARRY_EN
  ,
  output logic                                      SC_RegSHIFTER_Carry_Out
`endif
);

  localparam logic [DATAWIDTH_REGSHIFTER_AMOUNT-1:0] AMT_ZERO = '0;
  localparam logic [DATAWIDTH_REGSHIFTER_AMOUNT-1:0] AMT_ONE  =
    {{(DATAWIDTH_REGSHIFTER_AMOUNT-1){1'b0}}, 1'b1};

  state_t                                    state_reg, state_next;
  logic [DATAWIDTH_BUS-1:0]                  data_reg, data_next;
  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] mode_reg, mode_next;
  logic [DATAWIDTH_REGSHIFTER_AMOUNT-1:0]    count_reg, count_next;
  logic [DATAWIDTH_BUS-1:0]                  step_word;
  logic                                      step_bit;
  logic                                      step_moves;
  logic                                      load_event;
  logic                                      step_event;

  sc_regshifter_step #(
    .WIDTH (DATAWIDTH_BUS),
    .SEL_W (DATAWIDTH_REGSHIFTER_SELECTION)
  ) u_step (
    .word        (data_reg),
    .mode        (mode_reg),
    .word_next   (step_word),
    .shifted_bit (step_bit),
    .moves       (step_moves)
  );

  // Next-state, datapath and counter decisions for the controller.
  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    mode_next  = mode_reg;
    count_next = count_reg;
    load_event = 1'b0;
    step_event = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!SC_RegSHIFTER_Load_InLow) begin
          // Load wins over Start when both are requested.
          data_next  = SC_RegSHIFTER_DataBUS_In;
          load_event = 1'b1;
        end else if (!SC_RegSHIFTER_Start_InLow) begin
          mode_next  = SC_RegSHIFTER_ShiftSelection_InLow;
          count_next = SC_RegSHIFTER_ShiftAmount_In;
          if (SC_RegSHIFTER_ShiftAmount_In == AMT_ZERO) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        data_next  = step_word;
        step_event = 1'b1;
        count_next = count_reg - AMT_ONE;
        if (count_reg == AMT_ONE) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, data, latched mode and counter registers with synchronous reset.
  always_ff @(posedge SC_RegSHIFTER_CLOCK_50) begin
    if (SC_RegSHIFTER_Reset_InHigh) begin
      state_reg <= ST_IDLE;
      data_reg  <= '0;
      mode_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      mode_reg  <= mode_next;
      count_reg <= count_next;
    end
  end

  assign SC_RegSHIFTER_DataBUS_Out = data_reg;
  assign SC_RegSHIFTER_Busy_Out    = (state_reg == ST_SHIFT);
  assign SC_RegSHIFTER_Done_Out    = (state_reg == ST_DONE);

`ifdef SC_REGSHIFTER_CARRY_EN
  logic carry_reg, carry_next;

  // Carry captures the bit leaving the word; a load clears it, NOP steps keep it.
  always_comb begin
    carry_next = carry_reg;
    if (load_event) begin
      carry_next = 1'b0;
    end else if (step_event && step_moves) begin
      carry_next = step_bit;
    end
  end

  // Carry flop with synchronous reset.
  always_ff @(posedge SC_RegSHIFTER_CLOCK_50) begin
    if (SC_RegSHIFTER_Reset_InHigh) begin
      carry_reg <= 1'b0;
    end else begin
      carry_reg <= carry_next;
    end
  end

  assign SC_RegSHIFTER_Carry_Out = carry_reg;
`else
  // Without the carry output the shifted-out bit has no consumer.
  logic unused_carry;
  assign unused_carry = &{1'b0, step_bit, step_moves, load_event, step_event};
`endif

endmodule
